// File: rtl/emmc_link_deframer.sv
// emmc_link_deframer: device-side receive deframer for the eMMC serial link.
// Finds 3-word frame alignment via sync search plus ISERDES bitslip. It checks
// parity (and optionally sequence), then rebuilds the host's eMMC pin state.
// Ports:
//   clk_div, rst (sync, active-high)  word clock and reset
//   word_in[7:0]                      deserialized word, one per cycle
//   bitslip                           1-cycle slip request to the ISERDES
//   locked, frame_valid               alignment status / pin-update strobe
//   cmd_o, cmd_t, sd_dat_t, sd_dat_o  rebuilt host pin state (idle = released)
//   parity_err_cnt, seq_err_cnt       saturating error counters
// Optional feature: define EMMC_DEFRAMER_SEQ_CHECK_EN to enable sequence
// checking in LOCKED. Without it, seq_err_cnt is tied to zero.
module emmc_link_deframer #(
    parameter logic [7:0] SYNC_WORD   = 8'hA5,
    parameter int         LOCK_FRAMES = 4,
    parameter int         UNLOCK_ERRS = 3,
    parameter int         SLIP_WAIT   = 4
) (
    input  logic        clk_div,
    input  logic        rst,
    input  logic [7:0]  word_in,
    output logic        bitslip,
    output logic        locked,
    output logic        frame_valid,
    output logic        cmd_o,
    output logic        cmd_t,
    output logic        sd_dat_t,
    output logic [7:0]  sd_dat_o,
    output logic [15:0] parity_err_cnt,
    output logic [15:0] seq_err_cnt
);

    typedef enum logic [1:0] {HUNT, SLIP, CHECK, LOCKED} state_t;

    state_t     state, state_n;
    logic [1:0] pos, pos_n;
    logic [1:0] miss_cnt, miss_n;
    logic [7:0] wait_cnt, wait_n;
    logic [7:0] good_cnt, good_n;
    logic [7:0] bad_cnt, bad_n;
    logic [7:0] w1_q;
    logic       sync_ok;

    logic       is_sync;
    logic       par_ok;
    logic       slip_go;
    logic       par_err;
    logic       upd;
    logic       lock_go;
    logic       go_idle;
    logic [3:0] rx_seq;

    assign is_sync = (word_in == SYNC_WORD);
    // Even parity over W1 and W2 together is the same as par == ^{W1[7:1],W2}.
    assign par_ok  = ~^{w1_q, word_in};
    assign rx_seq  = w1_q[4:1];

    always_comb begin
        state_n = state;
        pos_n   = pos;
        miss_n  = miss_cnt;
        wait_n  = wait_cnt;
        good_n  = good_cnt;
        bad_n   = bad_cnt;
        slip_go = 1'b0;
        par_err = 1'b0;
        upd     = 1'b0;
        lock_go = 1'b0;
        go_idle = 1'b0;
        unique case (state)
            HUNT: begin
                pos_n = 2'd0;
                if (is_sync) begin
                    state_n = CHECK;
                    pos_n   = 2'd1;
                    good_n  = '0;
                    miss_n  = '0;
                end else if (miss_cnt == 2'd2) begin
                    slip_go = 1'b1;
                    state_n = SLIP;
                    wait_n  = '0;
                    miss_n  = '0;
                end else begin
                    miss_n = miss_cnt + 2'd1;
                end
            end
            SLIP: begin
                pos_n = 2'd0;
                if (wait_cnt == 8'(SLIP_WAIT - 1)) begin
                    state_n = HUNT;
                    miss_n  = '0;
                end else begin
                    wait_n = wait_cnt + 8'd1;
                end
            end
            CHECK: begin
                unique case (pos)
                    2'd0: begin
                        if (is_sync) begin
                            pos_n = 2'd1;
                        end else begin
                            slip_go = 1'b1;
                            state_n = SLIP;
                            wait_n  = '0;
                        end
                    end
                    2'd1: pos_n = 2'd2;
                    default: begin
                        pos_n = 2'd0;
                        if (!par_ok) begin
                            par_err = 1'b1;
                            slip_go = 1'b1;
                            state_n = SLIP;
                            wait_n  = '0;
                        end else if (good_cnt == 8'(LOCK_FRAMES - 1)) begin
                            lock_go = 1'b1;
                            upd     = 1'b1;
                            state_n = LOCKED;
                            bad_n   = '0;
                        end else begin
                            good_n = good_cnt + 8'd1;
                        end
                    end
                endcase
            end
            LOCKED: begin
                unique case (pos)
                    2'd0: pos_n = 2'd1;
                    2'd1: pos_n = 2'd2;
                    default: begin
                        pos_n   = 2'd0;
                        par_err = !par_ok;
                        if (sync_ok && par_ok) begin
                            upd   = 1'b1;
                            bad_n = '0;
                        end else if (bad_cnt == 8'(UNLOCK_ERRS - 1)) begin
                            go_idle = 1'b1;
                            state_n = HUNT;
                            bad_n   = '0;
                            miss_n  = '0;
                        end else begin
                            bad_n = bad_cnt + 8'd1;
                        end
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge clk_div) begin
        if (rst) begin
            state          <= HUNT;
            pos            <= '0;
            miss_cnt       <= '0;
            wait_cnt       <= '0;
            good_cnt       <= '0;
            bad_cnt        <= '0;
            w1_q           <= '0;
            sync_ok        <= 1'b0;
            bitslip        <= 1'b0;
            locked         <= 1'b0;
            frame_valid    <= 1'b0;
            cmd_o          <= 1'b1;
            cmd_t          <= 1'b1;
            sd_dat_t       <= 1'b1;
            sd_dat_o       <= 8'hFF;
            parity_err_cnt <= '0;
        end else begin
            state       <= state_n;
            pos         <= pos_n;
            miss_cnt    <= miss_n;
            wait_cnt    <= wait_n;
            good_cnt    <= good_n;
            bad_cnt     <= bad_n;
            bitslip     <= slip_go;
            frame_valid <= upd;
            if (pos == 2'd0) sync_ok <= is_sync;
            if (pos == 2'd1) w1_q <= word_in;
            if (lock_go) locked <= 1'b1;
            if (go_idle) locked <= 1'b0;
            if (upd) begin
                cmd_o    <= w1_q[7];
                cmd_t    <= w1_q[6];
                sd_dat_t <= w1_q[5];
                sd_dat_o <= word_in;
            end else if (go_idle) begin
                cmd_o    <= 1'b1;
                cmd_t    <= 1'b1;
                sd_dat_t <= 1'b1;
                sd_dat_o <= 8'hFF;
            end
            if (par_err && parity_err_cnt != 16'hFFFF)
                parity_err_cnt <= parity_err_cnt + 16'd1;
        end
    end

`ifdef EMMC_DEFRAMER_SEQ_CHECK_EN
    logic [3:0] exp_seq;

    // The locking frame seeds the expected value; later good frames compare.
    always_ff @(posedge clk_div) begin
        if (rst) begin
            exp_seq     <= '0;
            seq_err_cnt <= '0;
        end else if (lock_go) begin
            exp_seq <= rx_seq + 4'd1;
        end else if (upd) begin
            exp_seq <= rx_seq + 4'd1;
            if (rx_seq != exp_seq && seq_err_cnt != 16'hFFFF)
                seq_err_cnt <= seq_err_cnt + 16'd1;
        end
    end
`else
    logic unused_seq;
    assign unused_seq  = ^rx_seq;
    assign seq_err_cnt = '0;
`endif

endmodule

// File: tb/tb_emmc_link_deframer.sv
// tb_emmc_link_deframer: directed bench for emmc_link_deframer.
// Drives frames through a word-rotating ISERDES model and checks pin state.
module tb_emmc_link_deframer;

    logic        clk_div = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  word_in = 8'h00;
    logic        bitslip;
    logic        locked;
    logic        frame_valid;
    logic        cmd_o;
    logic        cmd_t;
    logic        sd_dat_t;
    logic [7:0]  sd_dat_o;
    logic [15:0] parity_err_cnt;
    logic [15:0] seq_err_cnt;

    int vectors = 0;
    int miscompares = 0;
    int r = 0;
    int slips = 0;
    int cyc = 0;
    int last_slip = -1;
    int min_gap = 1000;

    emmc_link_deframer dut (
        .clk_div        (clk_div),
        .rst            (rst),
        .word_in        (word_in),
        .bitslip        (bitslip),
        .locked         (locked),
        .frame_valid    (frame_valid),
        .cmd_o          (cmd_o),
        .cmd_t          (cmd_t),
        .sd_dat_t       (sd_dat_t),
        .sd_dat_o       (sd_dat_o),
        .parity_err_cnt (parity_err_cnt),
        .seq_err_cnt    (seq_err_cnt)
    );

    always #5 clk_div = ~clk_div;

    function automatic logic [7:0] rot(input logic [7:0] w, input int n);
        logic [7:0] t;
        t = w;
        for (int i = 0; i < n; i++) t = {t[6:0], t[7]};
        return t;
    endfunction

    function automatic logic [7:0] mk_w1(input logic [3:0] s, input logic [7:0] d);
        logic [6:0] hi;
        hi = {1'b1, 1'b0, 1'b1, s};
        return {hi, ^{hi, d}};
    endfunction

    // One word through the ISERDES model; a slip request rotates back by one.
    task automatic send_word(input logic [7:0] w);
        word_in = rot(w, r);
        @(posedge clk_div);
        #1;
        cyc++;
        if (bitslip) begin
            if (last_slip >= 0 && cyc - last_slip < min_gap)
                min_gap = cyc - last_slip;
            last_slip = cyc;
            slips++;
            r = (r + 7) % 8;
        end
    endtask

    task automatic send_frame(input logic [3:0] s, input logic [7:0] d,
                              input logic [7:0] flip, output logic [2:0] fv);
        send_word(8'hA5);
        fv[0] = frame_valid;
        send_word(mk_w1(s, d));
        fv[1] = frame_valid;
        send_word(d ^ flip);
        fv[2] = frame_valid;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        r = 0;
        send_word(8'h00);
        send_word(8'h00);
        rst = 1'b0;
    endtask

    task automatic lock_up(input logic [3:0] base);
        logic [2:0] fv;
        for (int i = 0; i < 4; i++) send_frame(base + 4'(i), 8'h3C, 8'h00, fv);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({locked, bitslip, frame_valid, cmd_o, cmd_t, sd_dat_t} !== 6'b000111) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 000111",
                     {locked, bitslip, frame_valid, cmd_o, cmd_t, sd_dat_t});
        end
        vectors++;
        if (sd_dat_o !== 8'hFF) begin
            miscompares++;
            $display("FAIL reset_dat: got %h want ff", sd_dat_o);
        end
        vectors++;
        if ({parity_err_cnt, seq_err_cnt} !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_cnt: got %h/%h want 0/0", parity_err_cnt, seq_err_cnt);
        end
    endtask

    task automatic test_aligned();
        logic [2:0] fv;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_frame(4'(i), 8'h3C, 8'h00, fv);
            if (i == 2) begin
                vectors++;
                if (locked !== 1'b0 || fv !== 3'b000 || sd_dat_o !== 8'hFF) begin
                    miscompares++;
                    $display("FAIL aligned_prelock: got lk=%b fv=%b d=%h want 0 000 ff",
                             locked, fv, sd_dat_o);
                end
            end
        end
        vectors++;
        if (locked !== 1'b1 || fv !== 3'b100) begin
            miscompares++;
            $display("FAIL aligned_lock: got lk=%b fv=%b want 1 100", locked, fv);
        end
        vectors++;
        if ({cmd_o, cmd_t, sd_dat_t, sd_dat_o} !== {3'b101, 8'h3C}) begin
            miscompares++;
            $display("FAIL aligned_pins: got %b %h want 101 3c",
                     {cmd_o, cmd_t, sd_dat_t}, sd_dat_o);
        end
        for (int i = 4; i < 8; i++) begin
            send_frame(4'(i), 8'h3C, 8'h00, fv);
            vectors++;
            if (fv !== 3'b100) begin
                miscompares++;
                $display("FAIL aligned_fv%0d: got %b want 100", i, fv);
            end
        end
    endtask

    task automatic test_bitslip();
        logic [2:0] fv;
        do_reset();
        r = 3;
        slips = 0;
        last_slip = -1;
        min_gap = 1000;
        for (int i = 0; i < 40 && !locked; i++)
            send_frame(4'(i % 2), 8'h3C, 8'h00, fv);
        vectors++;
        if (locked !== 1'b1) begin
            miscompares++;
            $display("FAIL slip_lock: got %b want 1 (timeout)", locked);
        end
        vectors++;
        if (slips != 3) begin
            miscompares++;
            $display("FAIL slip_count: got %0d want 3", slips);
        end
        vectors++;
        if (min_gap < 7) begin
            miscompares++;
            $display("FAIL slip_gap: got %0d want >=7", min_gap);
        end
        vectors++;
        if ({cmd_o, cmd_t, sd_dat_t, sd_dat_o} !== {3'b101, 8'h3C}) begin
            miscompares++;
            $display("FAIL slip_pins: got %b %h want 101 3c",
                     {cmd_o, cmd_t, sd_dat_t}, sd_dat_o);
        end
    endtask

    task automatic test_parity_unlock();
        logic [2:0] fv;
        do_reset();
        lock_up(4'd0);
        send_frame(4'd4, 8'h3C, 8'h01, fv);
        send_frame(4'd5, 8'h3C, 8'h01, fv);
        vectors++;
        if (locked !== 1'b1 || sd_dat_o !== 8'h3C || fv !== 3'b000) begin
            miscompares++;
            $display("FAIL par_hold: got lk=%b d=%h fv=%b want 1 3c 000",
                     locked, sd_dat_o, fv);
        end
        send_frame(4'd6, 8'h3C, 8'h01, fv);
        vectors++;
        if (parity_err_cnt !== 16'd3) begin
            miscompares++;
            $display("FAIL par_cnt: got %0d want 3", parity_err_cnt);
        end
        vectors++;
        if ({locked, cmd_o, cmd_t, sd_dat_t, sd_dat_o} !== {4'b0111, 8'hFF}) begin
            miscompares++;
            $display("FAIL par_unlock: got %b %h want 0111 ff",
                     {locked, cmd_o, cmd_t, sd_dat_t}, sd_dat_o);
        end
        for (int i = 0; i < 4; i++) begin
            send_frame(4'(7 + i), 8'h5A, 8'h00, fv);
            if (i == 2) begin
                vectors++;
                if (locked !== 1'b0) begin
                    miscompares++;
                    $display("FAIL par_relock_early: got %b want 0", locked);
                end
            end
        end
        vectors++;
        if (locked !== 1'b1 || sd_dat_o !== 8'h5A) begin
            miscompares++;
            $display("FAIL par_relock: got lk=%b d=%h want 1 5a", locked, sd_dat_o);
        end
    endtask

    task automatic test_error_hold();
        logic [2:0] fv;
        do_reset();
        lock_up(4'd0);
        send_frame(4'd4, 8'h3C, 8'h80, fv);
        send_frame(4'd5, 8'h3C, 8'h80, fv);
        vectors++;
        if (sd_dat_o !== 8'h3C) begin
            miscompares++;
            $display("FAIL hold_bad2: got %h want 3c", sd_dat_o);
        end
        send_frame(4'd6, 8'h5A, 8'h00, fv);
        vectors++;
        if (fv !== 3'b100 || sd_dat_o !== 8'h5A) begin
            miscompares++;
            $display("FAIL hold_good: got fv=%b d=%h want 100 5a", fv, sd_dat_o);
        end
        send_frame(4'd7, 8'h3C, 8'h80, fv);
        send_frame(4'd8, 8'h3C, 8'h80, fv);
        vectors++;
        if (locked !== 1'b1 || sd_dat_o !== 8'h5A) begin
            miscompares++;
            $display("FAIL hold_locked: got lk=%b d=%h want 1 5a", locked, sd_dat_o);
        end
        vectors++;
        if (parity_err_cnt !== 16'd4) begin
            miscompares++;
            $display("FAIL hold_cnt: got %0d want 4", parity_err_cnt);
        end
    endtask

    task automatic test_seq();
        logic [2:0]  fv;
        logic [15:0] exp_errs;
`ifdef EMMC_DEFRAMER_SEQ_CHECK_EN
        exp_errs = 16'd1;
`else
        exp_errs = 16'd0;
`endif
        do_reset();
        lock_up(4'd0);
        send_frame(4'd4, 8'h3C, 8'h00, fv);
        send_frame(4'd5, 8'h3C, 8'h00, fv);
        send_frame(4'd7, 8'h77, 8'h00, fv);
        vectors++;
        if (locked !== 1'b1 || sd_dat_o !== 8'h77 || fv !== 3'b100) begin
            miscompares++;
            $display("FAIL seq_update: got lk=%b d=%h fv=%b want 1 77 100",
                     locked, sd_dat_o, fv);
        end
        vectors++;
        if (seq_err_cnt !== exp_errs) begin
            miscompares++;
            $display("FAIL seq_cnt: got %0d want %0d", seq_err_cnt, exp_errs);
        end
        send_frame(4'd8, 8'h3C, 8'h00, fv);
        vectors++;
        if (seq_err_cnt !== exp_errs || locked !== 1'b1) begin
            miscompares++;
            $display("FAIL seq_resync: got cnt=%0d lk=%b want %0d 1",
                     seq_err_cnt, locked, exp_errs);
        end
    endtask

    task automatic test_reset_midframe();
        logic [2:0] fv;
        do_reset();
        lock_up(4'd0);
        send_frame(4'd4, 8'h3C, 8'h01, fv);
        send_word(8'hA5);
        rst = 1'b1;
        send_word(mk_w1(4'd5, 8'h3C));
        rst = 1'b0;
        vectors++;
        if ({locked, bitslip, frame_valid, cmd_o, cmd_t, sd_dat_t, sd_dat_o}
            !== {6'b000111, 8'hFF}) begin
            miscompares++;
            $display("FAIL mid_rst_state: got %b %h want 000111 ff",
                     {locked, bitslip, frame_valid, cmd_o, cmd_t, sd_dat_t}, sd_dat_o);
        end
        vectors++;
        if (parity_err_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL mid_rst_cnt: got %0d want 0", parity_err_cnt);
        end
        send_word(8'h3C);
        for (int i = 0; i < 4; i++) begin
            send_frame(4'(6 + i), 8'h3C, 8'h00, fv);
            if (i == 2) begin
                vectors++;
                if (locked !== 1'b0) begin
                    miscompares++;
                    $display("FAIL mid_rst_early: got %b want 0", locked);
                end
            end
        end
        vectors++;
        if (locked !== 1'b1 || sd_dat_o !== 8'h3C) begin
            miscompares++;
            $display("FAIL mid_rst_relock: got lk=%b d=%h want 1 3c", locked, sd_dat_o);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_aligned();
        test_bitslip();
        test_parity_unlock();
        test_error_hold();
        test_seq();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/emmc_link_deframer.md
# emmc_link_deframer

Device-side receive deframer for the eMMC chip-to-chip serial link. Takes the 8-bit parallel words from the remote end's ISERDES in the `clk_div` domain and finds frame alignment by sync search plus bitslip. It checks parity and sequence, then rebuilds the host's eMMC pin state (`cmd_o`, `cmd_t`, `sd_dat_t`, `sd_dat_o`) so the remote side can drive its eMMC pads. It is the counterpart of the host-side serializer that packs those same signals onto `dataout_p/n`.

## Interface
Parameters:
- `SYNC_WORD`, 8'hA5: frame sync byte.
- `LOCK_FRAMES`, 4: consecutive good frames needed to declare lock.
- `UNLOCK_ERRS`, 3: consecutive bad frames that drop lock.
- `SLIP_WAIT`, 4: idle cycles after each bitslip pulse (ISERDES settle time).

Ports:
- `clk_div` in 1: word clock; one word per cycle, no valid strobe.
- `rst` in 1: reset, synchronous, active-high.
- `word_in` in 8: deserialized word, bit 7 first on the wire.
- `bitslip` out 1: one-cycle pulse to the ISERDES.
- `locked` out 1: alignment achieved.
- `frame_valid` out 1: one-cycle pulse when the pin outputs are updated.
- `cmd_o`, `cmd_t`, `sd_dat_t` out 1 each: rebuilt host pin state.
- `sd_dat_o` out 8: rebuilt host data bus.
- `parity_err_cnt` out 16: saturating count of parity errors.
- `seq_err_cnt` out 16: saturating count of sequence errors.

## Operation
Frame format, 3 words:
- W0: `SYNC_WORD`.
- W1: `{cmd_o, cmd_t, sd_dat_t, seq[3:0], par}`.
- W2: `sd_dat_o[7:0]`.
- `par` is defined so that `par == ^{W1[7:1], W2}`. `seq` increments mod 16 per frame at the transmitter.

State machine (`pos` = word index 0..2 within the frame):
- HUNT
  - `word_in == SYNC_WORD` → CHECK with `pos=1` and `good=0`.
  - 3 consecutive cycles with no sync → pulse `bitslip`, then SLIP.
- SLIP
  - Wait `SLIP_WAIT` cycles → HUNT. The no-sync counter clears.
- CHECK
  - Track `pos`. At `pos=0` the word must equal `SYNC_WORD`. At end of W2, parity must pass.
  - Each pass increments `good`. When `good == LOCK_FRAMES` → LOCKED.
  - Any failure → pulse `bitslip`, then SLIP.
- LOCKED
  - A frame is good if its sync matches and its parity passes.
  - A bad frame increments `bad`. A good frame clears `bad`.
  - `bad == UNLOCK_ERRS` → HUNT, with `locked` deasserted and outputs returned to idle.

Output update rules:
- Pin outputs update only on a good frame while LOCKED. Otherwise they hold their last values.
- Idle pin state: `cmd_o=1`, `cmd_t=1`, `sd_dat_t=1`, `sd_dat_o=8'hFF` (bus released).

Error counting:
- A parity error in CHECK or LOCKED increments `parity_err_cnt`.
- A sync miss in LOCKED counts as a bad frame only; it does not increment `parity_err_cnt`.
- Both counters saturate at 16'hFFFF.

Data equal to `SYNC_WORD`:
- While LOCKED or CHECK, the value is ignored at `pos≠0`.
- In HUNT it may cause a false candidate, which CHECK rejects.

## Timing
- Reset values:
  - Outputs: `locked=0`, `bitslip=0`, `frame_valid=0`, pins idle, both counters 0.
  - Internal: state HUNT, `pos=0`.
- Latency: outputs and `frame_valid` update one cycle after W2 is sampled.
- `bitslip` is high for exactly 1 cycle and is never reasserted within `SLIP_WAIT` cycles.
- `locked` asserts on the same edge as the first LOCKED output update. That update comes from the `LOCK_FRAMES`-th good frame.
- `locked` deasserts, and the pins go idle, on the edge that ends the `UNLOCK_ERRS`-th consecutive bad frame.
- Reset asserted mid-frame: on the next edge, all state returns to reset values. No partial frame is applied.

## Configuration
- `EMMC_DEFRAMER_SEQ_CHECK_EN` defined:
  - In LOCKED, each good frame's `seq` must equal the previous seq + 1 (mod 16). The first frame after lock only loads the expected value.
  - A mismatch increments `seq_err_cnt` and reloads the expected value.
  - The pins still update, and a mismatch does not count toward unlock.
- Not defined: seq bits are ignored and `seq_err_cnt` is tied to 0.

## Test plan
- Aligned stream of frames (A5, 8'b1_0_1_0001_p, 3C) → `locked`=1 after 4 frames; `sd_dat_o`=8'h3C, `cmd_o`=1, `cmd_t`=0, `sd_dat_t`=1, with `frame_valid` pulsing every 3 cycles.
- Stream bit-rotated by 3 → `bitslip` pulses spaced at least `SLIP_WAIT`+3 cycles apart; after the model ISERDES has slipped 3 times, lock is reached with correct pins.
- While locked, flip one W2 bit in 3 consecutive frames → `parity_err_cnt`=3, `locked`=0, pins idle (8'hFF, `cmd_t`=1); clean data then relocks.
- While locked, flip one W2 bit in 2 frames, then send 1 good frame, then 2 bad frames → `locked` stays 1, pins hold through the bad frames, `parity_err_cnt`=4.
- With the macro defined, skip seq 5→7 → `seq_err_cnt`=1, `locked` stays 1, pins update. Without the macro, `seq_err_cnt` stays 0.
- Assert `rst` for 1 cycle during W1 while locked → the next cycle shows reset values and the bench observes a full relock sequence.
